// File: rtl/spl_tx_wr_arbiter.sv
// rtl/spl_tx_wr_arbiter.sv - N-channel round-robin TX write arbiter with tagged response routing
module spl_tx_wr_arbiter #(
  parameter int N_CH     = 4,
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       afu_tx_wr_valid,
  input  logic [N_CH-1:0]       afu_tx_intr_valid,
  input  logic [N_CH*99-1:0]    afu_tx_wr_hdr,
  input  logic [N_CH*512-1:0]   afu_tx_data,
  output logic [N_CH-1:0]       afu_tx_wr_almostfull,
  input  logic                  cci_tx_wr_almostfull,
  output logic                  spl_tx_wr_valid,
  output logic                  spl_tx_intr_valid,
  output logic [98:0]           spl_tx_wr_hdr,
  output logic [511:0]          spl_tx_data,
  input  logic                  cci_rx_wr_valid1,
  input  logic [17:0]           cci_rx_hdr1,
  output logic [N_CH-1:0]       afu_rx_wr_valid1,
  output logic [17:0]           afu_rx_hdr1,
  output logic [1:0]            err_sticky
);

  localparam int CH_W = $clog2(N_CH);
  localparam int AW   = $clog2(DEPTH);
  localparam int EW   = 1 + 99 + 512;  // {kind, hdr, data}

  logic [EW-1:0]    r_mem  [N_CH][DEPTH];
  logic [AW-1:0]    r_wptr [N_CH];
  logic [AW-1:0]    r_rptr [N_CH];
  logic [AW:0]      r_cnt  [N_CH];
  logic [CH_W-1:0]  r_last;
  logic             r_wr_valid;
  logic             r_intr_valid;
  logic [98:0]      r_hdr;
  logic [511:0]     r_data;
  logic [1:0]       r_err;
  logic [N_CH-1:0]  r_rx_valid;
  logic [17:0]      r_rx_hdr;

  logic [EW-1:0]    w_entry [N_CH];
  logic [N_CH-1:0]  w_push;
  logic [N_CH-1:0]  w_pop;
  logic [N_CH-1:0]  w_accept;
  logic [N_CH-1:0]  w_ovf;
  logic [N_CH-1:0]  w_nonempty;
  logic             w_gnt_vld;
  logic [CH_W-1:0]  w_gnt_idx;
  logic [EW-1:0]    w_head;
  logic [98:0]      w_tag_hdr;
  logic [CH_W-1:0]  w_rx_tag;
  logic             w_rx_tag_ok;
  logic [17:0]      w_rx_hdr_clr;

  // Per-channel push/pop qualification; a full FIFO popped this cycle still accepts
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // write wins over a simultaneous interrupt, so kind is 1 only for a lone intr
      w_entry[i]    = {~afu_tx_wr_valid[i], afu_tx_wr_hdr[99*i +: 99], afu_tx_data[512*i +: 512]};
      w_push[i]     = afu_tx_wr_valid[i] | afu_tx_intr_valid[i];
      w_nonempty[i] = (r_cnt[i] != '0);
      w_pop[i]      = w_gnt_vld && (w_gnt_idx == CH_W'(i));
      w_accept[i]   = w_push[i] && ((r_cnt[i] != (AW+1)'(DEPTH)) || w_pop[i]);
      w_ovf[i]      = w_push[i] && !w_accept[i];
      afu_tx_wr_almostfull[i] = (r_cnt[i] >= (AW+1)'(DEPTH - AF_SLACK));
    end
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= N_CH; k++) begin
      if (!w_gnt_vld && !cci_tx_wr_almostfull &&
          w_nonempty[(int'(r_last) + k) % N_CH]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = CH_W'((int'(r_last) + k) % N_CH);
      end
    end
  end

  // Head of the granted FIFO with the channel tag stamped into the mdata field
  always_comb begin
    w_head    = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];
    w_tag_hdr = w_head[610:512];
    w_tag_hdr[13 -: CH_W] = w_gnt_idx;
  end

  // FIFO storage; pointers alone define validity so the array needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_accept[i]) r_mem[i][r_wptr[i]] <= w_entry[i];
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_accept[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])    r_rptr[i] <= r_rptr[i] + 1'b1;
        if (w_accept[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_accept[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  // Registered CCI output stage; hdr/data hold when nothing is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last       <= CH_W'(N_CH - 1);
      r_wr_valid   <= 1'b0;
      r_intr_valid <= 1'b0;
      r_hdr        <= '0;
      r_data       <= '0;
    end else if (w_gnt_vld) begin
      r_last       <= w_gnt_idx;
      r_wr_valid   <= ~w_head[EW-1];
      r_intr_valid <= w_head[EW-1];
      r_hdr        <= w_tag_hdr;
      r_data       <= w_head[511:0];
    end else begin
      r_wr_valid   <= 1'b0;
      r_intr_valid <= 1'b0;
    end
  end

  // Sticky error flags: overflow drop and write/intr collision
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= '0;
    end else begin
      r_err[0] <= r_err[0] | (|w_ovf);
      r_err[1] <= r_err[1] | (|(afu_tx_wr_valid & afu_tx_intr_valid));
    end
  end

  always_comb begin
    w_rx_tag     = cci_rx_hdr1[13 -: CH_W];
    w_rx_tag_ok  = ({1'b0, w_rx_tag} < (CH_W+1)'(N_CH));
    w_rx_hdr_clr = cci_rx_hdr1;
    w_rx_hdr_clr[13 -: CH_W] = '0;
  end

  // Write-response demux back to the owning channel; out-of-range tags vanish
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= '0;
      r_rx_hdr   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_rx_valid[i] <= cci_rx_wr_valid1 && w_rx_tag_ok && (w_rx_tag == CH_W'(i));
      end
      if (cci_rx_wr_valid1 && w_rx_tag_ok) r_rx_hdr <= w_rx_hdr_clr;
    end
  end

  assign spl_tx_wr_valid   = r_wr_valid;
  assign spl_tx_intr_valid = r_intr_valid;
  assign spl_tx_wr_hdr     = r_hdr;
  assign spl_tx_data       = r_data;
  assign afu_rx_wr_valid1  = r_rx_valid;
  assign afu_rx_hdr1       = r_rx_hdr;
  assign err_sticky        = r_err;

endmodule

// File: tb/tb_spl_tx_wr_arbiter.sv
// tb/tb_spl_tx_wr_arbiter.sv - directed-vector bench for spl_tx_wr_arbiter
module tb_spl_tx_wr_arbiter;

  localparam int N_CH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_CH-1:0]      afu_tx_wr_valid;
  logic [N_CH-1:0]      afu_tx_intr_valid;
  logic [N_CH*99-1:0]   afu_tx_wr_hdr;
  logic [N_CH*512-1:0]  afu_tx_data;
  logic [N_CH-1:0]      afu_tx_wr_almostfull;
  logic                 cci_tx_wr_almostfull;
  logic                 spl_tx_wr_valid;
  logic                 spl_tx_intr_valid;
  logic [98:0]          spl_tx_wr_hdr;
  logic [511:0]         spl_tx_data;
  logic                 cci_rx_wr_valid1;
  logic [17:0]          cci_rx_hdr1;
  logic [N_CH-1:0]      afu_rx_wr_valid1;
  logic [17:0]          afu_rx_hdr1;
  logic [1:0]           err_sticky;

  int n_vec = 0;
  int n_err = 0;

  spl_tx_wr_arbiter #(.N_CH(N_CH), .DEPTH(8), .AF_SLACK(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .afu_tx_wr_valid      (afu_tx_wr_valid),
    .afu_tx_intr_valid    (afu_tx_intr_valid),
    .afu_tx_wr_hdr        (afu_tx_wr_hdr),
    .afu_tx_data          (afu_tx_data),
    .afu_tx_wr_almostfull (afu_tx_wr_almostfull),
    .cci_tx_wr_almostfull (cci_tx_wr_almostfull),
    .spl_tx_wr_valid      (spl_tx_wr_valid),
    .spl_tx_intr_valid    (spl_tx_intr_valid),
    .spl_tx_wr_hdr        (spl_tx_wr_hdr),
    .spl_tx_data          (spl_tx_data),
    .cci_rx_wr_valid1     (cci_rx_wr_valid1),
    .cci_rx_hdr1          (cci_rx_hdr1),
    .afu_rx_wr_valid1     (afu_rx_wr_valid1),
    .afu_rx_hdr1          (afu_rx_hdr1),
    .err_sticky           (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic wr, input logic intr,
                      input logic [98:0] hdr, input logic [511:0] data);
    afu_tx_wr_valid[ch]          = wr;
    afu_tx_intr_valid[ch]        = intr;
    afu_tx_wr_hdr[99*ch +: 99]   = hdr;
    afu_tx_data[512*ch +: 512]   = data;
  endtask

  task automatic idle_in();
    afu_tx_wr_valid   = '0;
    afu_tx_intr_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset                = 1'b0;
    afu_tx_wr_valid      = '0;
    afu_tx_intr_valid    = '0;
    afu_tx_wr_hdr        = '0;
    afu_tx_data          = '0;
    cci_tx_wr_almostfull = 1'b0;
    cci_rx_wr_valid1     = 1'b0;
    cci_rx_hdr1          = '0;
    do_reset();

    check("rst_wr_valid",   64'(spl_tx_wr_valid), 64'd0);
    check("rst_intr_valid", 64'(spl_tx_intr_valid), 64'd0);
    check("rst_af",         64'(afu_tx_wr_almostfull), 64'd0);
    check("rst_err",        64'(err_sticky), 64'd0);
    check("rst_rx_valid",   64'(afu_rx_wr_valid1), 64'd0);

    // single write on ch2: valid two edges after the push edge
    push(2, 1'b1, 1'b0, 99'h12, {64{8'hA5}});
    tick();
    idle_in();
    check("t1_lat1_valid", 64'(spl_tx_wr_valid), 64'd0);
    tick();
    check("t1_valid",    64'(spl_tx_wr_valid), 64'd1);
    check("t1_intr",     64'(spl_tx_intr_valid), 64'd0);
    check("t1_tag",      64'(spl_tx_wr_hdr[13:12]), 64'd2);
    check("t1_hdr",      64'(spl_tx_wr_hdr), 64'h2012);
    check("t1_data",     64'(spl_tx_data == {64{8'hA5}}), 64'd1);
    tick();
    check("t1_drop",     64'(spl_tx_wr_valid), 64'd0);
    check("t1_hdr_hold", 64'(spl_tx_wr_hdr), 64'h2012);

    // all four channels at once: issued ch0..ch3 on consecutive cycles
    do_reset();
    for (int i = 0; i < N_CH; i++) push(i, 1'b1, 1'b0, 99'(32'h100 + i), 512'(i + 1));
    tick();
    idle_in();
    for (int i = 0; i < N_CH; i++) begin
      tick();
      check($sformatf("t2_valid%0d", i), 64'(spl_tx_wr_valid), 64'd1);
      check($sformatf("t2_hdr%0d", i),   64'(spl_tx_wr_hdr), 64'(32'h100 + i + (i << 12)));
      check($sformatf("t2_data%0d", i),  64'(spl_tx_data), 64'(i + 1));
    end
    tick();
    check("t2_idle", 64'(spl_tx_wr_valid), 64'd0);
    // last grant was ch3, so a ch1+ch0 pair must go ch0 first
    push(1, 1'b1, 1'b0, 99'h0, 512'h51);
    push(0, 1'b1, 1'b0, 99'h0, 512'h50);
    tick();
    idle_in();
    tick();
    check("t2_wrap_first",  64'(spl_tx_data), 64'h50);
    tick();
    check("t2_wrap_second", 64'(spl_tx_data), 64'h51);

    // CCI stall with ch1 holding three entries
    cci_tx_wr_almostfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) push(1, 1'b1, 1'b0, 99'h0, 512'(10 + k));
      else idle_in();
      tick();
      check($sformatf("t3_hold%0d", k), 64'(spl_tx_wr_valid), 64'd0);
    end
    idle_in();
    cci_tx_wr_almostfull = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_valid%0d", k), 64'(spl_tx_wr_valid), 64'd1);
      check($sformatf("t3_data%0d", k),  64'(spl_tx_data), 64'(10 + k));
    end
    tick();
    check("t3_no_dup", 64'(spl_tx_wr_valid), 64'd0);

    // fill ch0 to overflow behind a stalled CCI
    do_reset();
    check("t4_err_clear", 64'(err_sticky), 64'd0);
    cci_tx_wr_almostfull = 1'b1;
    for (int k = 0; k < 8; k++) begin
      push(0, 1'b1, 1'b0, 99'h0, 512'(20 + k));
      tick();
      check($sformatf("t4_af%0d", k + 1), 64'(afu_tx_wr_almostfull[0]), 64'((k + 1) >= 6));
    end
    check("t4_no_ovf_yet", 64'(err_sticky[0]), 64'd0);
    push(0, 1'b1, 1'b0, 99'h0, 512'd99);
    tick();
    idle_in();
    check("t4_ovf", 64'(err_sticky[0]), 64'd1);
    cci_tx_wr_almostfull = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("t4_valid%0d", k), 64'(spl_tx_wr_valid), 64'd1);
      check($sformatf("t4_data%0d", k),  64'(spl_tx_data), 64'(20 + k));
    end
    tick();
    check("t4_ninth_dropped", 64'(spl_tx_wr_valid), 64'd0);
    check("t4_af_clear", 64'(afu_tx_wr_almostfull[0]), 64'd0);

    // write+intr collision on ch3, then a lone interrupt
    check("t5_coll_clear", 64'(err_sticky[1]), 64'd0);
    push(3, 1'b1, 1'b1, 99'h5, 512'h33);
    tick();
    idle_in();
    check("t5_coll_err", 64'(err_sticky[1]), 64'd1);
    tick();
    check("t5_wr",   64'(spl_tx_wr_valid), 64'd1);
    check("t5_intr", 64'(spl_tx_intr_valid), 64'd0);
    check("t5_data", 64'(spl_tx_data), 64'h33);
    tick();
    check("t5_intr_dropped_wr",   64'(spl_tx_wr_valid), 64'd0);
    check("t5_intr_dropped_intr", 64'(spl_tx_intr_valid), 64'd0);
    push(3, 1'b0, 1'b1, 99'h7, 512'h44);
    tick();
    idle_in();
    tick();
    check("t5_lone_intr", 64'(spl_tx_intr_valid), 64'd1);
    check("t5_lone_wr",   64'(spl_tx_wr_valid), 64'd0);
    check("t5_lone_hdr",  64'(spl_tx_wr_hdr), 64'h3007);

    // response routing
    cci_rx_wr_valid1 = 1'b1;
    cci_rx_hdr1      = 18'h1ABC;
    tick();
    cci_rx_hdr1      = 18'h3FFFF;
    check("t6_rx_valid", 64'(afu_rx_wr_valid1), 64'h2);
    check("t6_rx_hdr",   64'(afu_rx_hdr1), 64'h0ABC);
    tick();
    cci_rx_wr_valid1 = 1'b0;
    check("t6_rx_valid3", 64'(afu_rx_wr_valid1), 64'h8);
    check("t6_rx_hdr3",   64'(afu_rx_hdr1), 64'h3CFFF);
    tick();
    check("t6_rx_idle",   64'(afu_rx_wr_valid1), 64'h0);

    // reset mid-operation discards buffered and in-flight entries
    cci_tx_wr_almostfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(1, 1'b1, 1'b0, 99'h0, 512'(60 + k));
      tick();
    end
    idle_in();
    cci_tx_wr_almostfull = 1'b0;
    tick();
    check("t7_inflight", 64'(spl_tx_wr_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("t7_rst_valid", 64'(spl_tx_wr_valid), 64'd0);
    check("t7_rst_hdr",   64'(spl_tx_wr_hdr), 64'd0);
    check("t7_rst_data",  64'(spl_tx_data), 64'd0);
    check("t7_rst_err",   64'(err_sticky), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t7_flushed%0d", k), 64'(spl_tx_wr_valid), 64'd0);
    end
    check("t7_af", 64'(afu_tx_wr_almostfull), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
